// File: rtl/sdram_arbiter_if.sv
// Bundle of the arbiter's bus signals: the controller-facing cs/we/addr/din
// side plus the two requester ports A and B.
// The slave modport is the arbiter's view. The master modport is the view of
// the surrounding system, which owns the requesters and the SDRAM controller.
interface sdram_arbiter_if;
  // Controller side
  logic        ram_ready;
  logic        ram_cs;
  logic        ram_we;
  logic [24:0] ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic        ram_refresh;
  // Port A (C64 core bus, high priority)
  logic        a_req;
  logic        a_we;
  logic [24:0] a_addr;
  logic [7:0]  a_din;
  logic        a_ack;
  logic [7:0]  a_dout;
  // Port B (ROM loader / DMA)
  logic        b_req;
  logic        b_we;
  logic [24:0] b_addr;
  logic [7:0]  b_din;
  logic        b_ack;
  logic [7:0]  b_dout;

  modport slave (
    input  ram_ready, ram_dout,
    input  a_req, a_we, a_addr, a_din,
    input  b_req, b_we, b_addr, b_din,
    output ram_cs, ram_we, ram_addr, ram_din, ram_refresh,
    output a_ack, a_dout, b_ack, b_dout
  );

  modport master (
    output ram_ready, ram_dout,
    output a_req, a_we, a_addr, a_din,
    output b_req, b_we, b_addr, b_din,
    input  ram_cs, ram_we, ram_addr, ram_din, ram_refresh,
    input  a_ack, a_dout, b_ack, b_dout
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Front-end of the 8-bit SDRAM controller. It arbitrates port A over port B,
// issues periodic refresh, and shapes every access into a fixed cs-high slot
// followed by one cs-low gap clock.
module sdram_arbiter #(
  parameter int CYCLE_LEN      = 8,
  parameter int REFRESH_CYCLES = 499,
  parameter int REFRESH_LEN    = 8,
  parameter int REFRESH_HIGH   = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  sdram_arbiter_if.slave  bus
);

  localparam int SLOT_MAX = (CYCLE_LEN > REFRESH_LEN) ? CYCLE_LEN : REFRESH_LEN;
  localparam int SLOT_W   = (SLOT_MAX > 1) ? $clog2(SLOT_MAX) : 1;
  localparam int REF_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  localparam logic [SLOT_W-1:0] CYC_LAST  = SLOT_W'(CYCLE_LEN - 1);
  localparam logic [SLOT_W-1:0] RHI_LAST  = SLOT_W'(REFRESH_HIGH - 1);
  localparam logic [SLOT_W-1:0] RLEN_LAST = SLOT_W'(REFRESH_LEN - 1);
  localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_REFRESH = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  state_t             state_q;
  logic [SLOT_W-1:0]  slot_cnt_q;
  logic               port_b_q;      // 0: slot belongs to A, 1: to B
  logic               ram_cs_q;
  logic               ram_we_q;
  logic [24:0]        ram_addr_q;
  logic [7:0]         ram_din_q;
  logic               ram_refresh_q;
  logic               a_ack_q;
  logic [7:0]         a_dout_q;
  logic               b_ack_q;
  logic [7:0]         b_dout_q;

  logic [REF_W-1:0]   ref_cnt_q;
  logic [REF_W-1:0]   ref_cnt_d;
  logic               ref_pend_q;
  logic               ref_pend_d;
  logic               refresh_take_s;

  // A refresh is started in this clock when IDLE picks the pending refresh.
  assign refresh_take_s = (state_q == S_IDLE) & bus.ram_ready & ref_pend_q;

  // Refresh interval timer: wraps every REFRESH_CYCLES ready clocks and flags a
  // pending refresh; a wrap always wins over the clear so no interval is lost.
  always_comb begin
    ref_cnt_d  = ref_cnt_q;
    ref_pend_d = ref_pend_q;
    if (!bus.ram_ready) begin
      ref_cnt_d  = '0;
      ref_pend_d = 1'b0;
    end else if (ref_cnt_q == REF_LAST) begin
      ref_cnt_d  = '0;
      ref_pend_d = 1'b1;
    end else begin
      ref_cnt_d = ref_cnt_q + REF_W'(1);
      if (refresh_take_s) begin
        ref_pend_d = 1'b0;
      end else begin
        ref_pend_d = ref_pend_q;
      end
    end
  end

  // Refresh timer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
    end else begin
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
    end
  end

  // Slot FSM: arbitration in IDLE, fixed-length access and refresh slots, and
  // all controller/requester outputs registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      slot_cnt_q    <= '0;
      port_b_q      <= 1'b0;
      ram_cs_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_din_q     <= '0;
      ram_refresh_q <= 1'b0;
      a_ack_q       <= 1'b0;
      a_dout_q      <= '0;
      b_ack_q       <= 1'b0;
      b_dout_q      <= '0;
    end else begin
      // Acks are single-clock pulses.
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!bus.ram_ready) begin
            state_q <= S_IDLE;
          end else if (ref_pend_q) begin
            ram_refresh_q <= 1'b1;
            slot_cnt_q    <= '0;
            state_q       <= S_REFRESH;
          end else if (bus.a_req) begin
            ram_we_q   <= bus.a_we;
            ram_addr_q <= bus.a_addr;
            ram_din_q  <= bus.a_din;
            ram_cs_q   <= 1'b1;
            port_b_q   <= 1'b0;
            slot_cnt_q <= '0;
            state_q    <= S_ACCESS;
          end else if (bus.b_req) begin
            ram_we_q   <= bus.b_we;
            ram_addr_q <= bus.b_addr;
            ram_din_q  <= bus.b_din;
            ram_cs_q   <= 1'b1;
            port_b_q   <= 1'b1;
            slot_cnt_q <= '0;
            state_q    <= S_ACCESS;
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_ACCESS: begin
          if (slot_cnt_q == CYC_LAST) begin
            // Last cs-high clock: complete towards the granted port only.
            if (port_b_q) begin
              b_ack_q <= 1'b1;
              if (!ram_we_q) begin
                b_dout_q <= bus.ram_dout;
              end else begin
                b_dout_q <= b_dout_q;
              end
            end else begin
              a_ack_q <= 1'b1;
              if (!ram_we_q) begin
                a_dout_q <= bus.ram_dout;
              end else begin
                a_dout_q <= a_dout_q;
              end
            end
            ram_cs_q <= 1'b0;
            ram_we_q <= 1'b0;
            state_q  <= S_GAP;
          end else begin
            slot_cnt_q <= slot_cnt_q + SLOT_W'(1);
          end
        end

        S_GAP: begin
          // One cs-low clock so the next grant is a fresh rising edge.
          state_q <= S_IDLE;
        end

        S_REFRESH: begin
          if (slot_cnt_q == RHI_LAST) begin
            ram_refresh_q <= 1'b0;
          end else begin
            ram_refresh_q <= ram_refresh_q;
          end
          if (slot_cnt_q == RLEN_LAST) begin
            state_q <= S_IDLE;
          end else begin
            slot_cnt_q <= slot_cnt_q + SLOT_W'(1);
          end
        end

        default: begin
          state_q       <= S_IDLE;
          ram_cs_q      <= 1'b0;
          ram_we_q      <= 1'b0;
          ram_refresh_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ram_cs      = ram_cs_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_din     = ram_din_q;
  assign bus.ram_refresh = ram_refresh_q;
  assign bus.a_ack       = a_ack_q;
  assign bus.a_dout      = a_dout_q;
  assign bus.b_ack       = b_ack_q;
  assign bus.b_dout      = b_dout_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios plus a randomized
// run against a transaction-level model (grant order, slot contents, acks, dout).
`timescale 1ns/1ps
module tb_sdram_arbiter;
  localparam int CYC   = 8;
  localparam int RCYC  = 499;
  localparam int RLEN  = 8;
  localparam int RHIGH = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sdram_arbiter_if bus_if();

  sdram_arbiter #(
    .CYCLE_LEN(CYC), .REFRESH_CYCLES(RCYC), .REFRESH_LEN(RLEN), .REFRESH_HIGH(RHIGH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus_if)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    reset_n = 1'b0;
    bus_if.ram_ready = 1'b0; bus_if.ram_dout = 8'h00;
    bus_if.a_req = 1'b0; bus_if.a_we = 1'b0; bus_if.a_addr = 25'h0; bus_if.a_din = 8'h00;
    bus_if.b_req = 1'b0; bus_if.b_we = 1'b0; bus_if.b_addr = 25'h0; bus_if.b_din = 8'h00;
    tick;
    tick;
    reset_n = 1'b1;
    bus_if.ram_ready = ready;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    bus_if.ram_ready = 1'b1; bus_if.ram_dout = 8'hFF;
    bus_if.a_req = 1'b1; bus_if.a_we = 1'b1; bus_if.a_addr = 25'h1FFFFFF; bus_if.a_din = 8'hFF;
    bus_if.b_req = 1'b1; bus_if.b_we = 1'b1; bus_if.b_addr = 25'h1FFFFFF; bus_if.b_din = 8'hFF;
    tick;
    tick;
    n_checks++;
    if ({bus_if.ram_cs, bus_if.ram_we, bus_if.ram_addr, bus_if.ram_din, bus_if.ram_refresh,
         bus_if.a_ack, bus_if.a_dout, bus_if.b_ack, bus_if.b_dout} !== 53'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got cs=%b we=%b addr=%h din=%h rf=%b aack=%b adout=%h back=%b bdout=%h, want all 0",
               bus_if.ram_cs, bus_if.ram_we, bus_if.ram_addr, bus_if.ram_din, bus_if.ram_refresh,
               bus_if.a_ack, bus_if.a_dout, bus_if.b_ack, bus_if.b_dout);
    end
  endtask

  // Scenario: single write on port A from IDLE.
  task automatic test_write_a;
    do_reset(1'b1);
    bus_if.a_we = 1'b1; bus_if.a_addr = 25'h0001234; bus_if.a_din = 8'h5A; bus_if.a_req = 1'b1;
    for (int i = 1; i <= CYC; i++) begin
      tick;
      n_checks++;
      if ({bus_if.ram_cs, bus_if.ram_we, bus_if.ram_addr, bus_if.ram_din, bus_if.a_ack} !==
          {1'b1, 1'b1, 25'h0001234, 8'h5A, 1'b0}) begin
        n_fail++;
        $display("FAIL wr_slot clk%0d: got cs=%b we=%b addr=%h din=%h ack=%b, want 1 1 0001234 5a 0",
                 i, bus_if.ram_cs, bus_if.ram_we, bus_if.ram_addr, bus_if.ram_din, bus_if.a_ack);
      end
    end
    tick;
    n_checks++;
    if ({bus_if.ram_cs, bus_if.ram_we, bus_if.a_ack, bus_if.b_ack} !== 4'b0010) begin
      n_fail++;
      $display("FAIL wr_ack: got cs=%b we=%b aack=%b back=%b, want 0 0 1 0",
               bus_if.ram_cs, bus_if.ram_we, bus_if.a_ack, bus_if.b_ack);
    end
    bus_if.a_req = 1'b0;
    tick;
    n_checks++;
    if ({bus_if.ram_cs, bus_if.a_ack} !== 2'b00) begin
      n_fail++;
      $display("FAIL wr_ack_pulse: got cs=%b aack=%b, want 0 0", bus_if.ram_cs, bus_if.a_ack);
    end
    tick;
    tick;
    n_checks++;
    if (bus_if.ram_cs !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_no_regrant: got cs=%b want 0", bus_if.ram_cs);
    end
  endtask

  // Scenario: A read, then B read; A's dout must survive B's access.
  task automatic test_read_b;
    do_reset(1'b1);
    bus_if.ram_dout = 8'h96;
    bus_if.a_we = 1'b0; bus_if.a_addr = 25'h00ABCDE; bus_if.a_req = 1'b1;
    for (int i = 0; i < CYC + 1; i++) tick;
    n_checks++;
    if ({bus_if.a_ack, bus_if.a_dout} !== {1'b1, 8'h96}) begin
      n_fail++;
      $display("FAIL rd_a: got ack=%b dout=%h, want 1 96", bus_if.a_ack, bus_if.a_dout);
    end
    bus_if.a_req = 1'b0;
    tick;
    tick;
    bus_if.ram_dout = 8'hC3;
    bus_if.b_we = 1'b0; bus_if.b_addr = 25'h1000000; bus_if.b_din = 8'h00; bus_if.b_req = 1'b1;
    tick;
    n_checks++;
    if ({bus_if.ram_cs, bus_if.ram_we, bus_if.ram_addr} !== {1'b1, 1'b0, 25'h1000000}) begin
      n_fail++;
      $display("FAIL rd_b_grant: got cs=%b we=%b addr=%h, want 1 0 1000000",
               bus_if.ram_cs, bus_if.ram_we, bus_if.ram_addr);
    end
    for (int i = 0; i < CYC; i++) tick;
    n_checks++;
    if ({bus_if.b_ack, bus_if.b_dout, bus_if.a_ack, bus_if.a_dout} !== {1'b1, 8'hC3, 1'b0, 8'h96}) begin
      n_fail++;
      $display("FAIL rd_b_ack: got back=%b bdout=%h aack=%b adout=%h, want 1 c3 0 96",
               bus_if.b_ack, bus_if.b_dout, bus_if.a_ack, bus_if.a_dout);
    end
    bus_if.b_req = 1'b0;
    bus_if.ram_dout = 8'h11;
    tick;
    tick;
    tick;
    n_checks++;
    if ({bus_if.b_dout, bus_if.a_dout} !== {8'hC3, 8'h96}) begin
      n_fail++;
      $display("FAIL rd_dout_hold: got bdout=%h adout=%h, want c3 96", bus_if.b_dout, bus_if.a_dout);
    end
  endtask

  // Scenario: A and B request together; A first, B one slot + gap + idle later.
  task automatic test_contention;
    int rise_t[4];
    logic [24:0] rise_addr[4];
    int n_rise = 0, a_cnt = 0, b_cnt = 0, a_t = -1, b_t = -1;
    logic prev_cs = 1'b0;
    do_reset(1'b1);
    bus_if.a_we = 1'b1; bus_if.a_addr = 25'h0000010; bus_if.a_din = 8'h11;
    bus_if.b_we = 1'b1; bus_if.b_addr = 25'h0000020; bus_if.b_din = 8'h22;
    bus_if.a_req = 1'b1; bus_if.b_req = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      tick;
      if (bus_if.ram_cs === 1'b1 && prev_cs === 1'b0 && n_rise < 4) begin
        rise_t[n_rise] = t; rise_addr[n_rise] = bus_if.ram_addr; n_rise++;
      end
      prev_cs = bus_if.ram_cs;
      if (bus_if.a_ack === 1'b1) begin a_cnt++; a_t = t; bus_if.a_req = 1'b0; end
      if (bus_if.b_ack === 1'b1) begin b_cnt++; b_t = t; bus_if.b_req = 1'b0; end
    end
    n_checks++;
    if (n_rise !== 2 || a_cnt !== 1 || b_cnt !== 1) begin
      n_fail++;
      $display("FAIL cont_counts: got rises=%0d aacks=%0d backs=%0d, want 2 1 1", n_rise, a_cnt, b_cnt);
    end
    n_checks++;
    if (n_rise < 2 || rise_t[0] !== 1 || rise_addr[0] !== 25'h0000010 ||
        rise_t[1] !== CYC + 3 || rise_addr[1] !== 25'h0000020) begin
      n_fail++;
      $display("FAIL cont_order: got rise0 t=%0d addr=%h rise1 t=%0d addr=%h, want t=1 0000010 t=%0d 0000020",
               rise_t[0], rise_addr[0], rise_t[1], rise_addr[1], CYC + 3);
    end
    n_checks++;
    if (a_t !== CYC + 1 || b_t !== 2 * CYC + 3) begin
      n_fail++;
      $display("FAIL cont_ack_time: got a=%0d b=%0d, want %0d %0d", a_t, b_t, CYC + 1, 2 * CYC + 3);
    end
  endtask

  // Scenario: refresh after the idle interval; A raised during refresh waits for it.
  task automatic test_refresh;
    int rf_first = -1, rf_last = -1, rf_cnt = 0, rf_rises = 0, cs_first = -1, ack_t = -1;
    logic prev_rf = 1'b0;
    int exp_rf = RCYC + 1;
    do_reset(1'b1);
    bus_if.a_we = 1'b0; bus_if.a_addr = 25'h0000777; bus_if.ram_dout = 8'h7E;
    for (int t = 1; t <= exp_rf + 30; t++) begin
      tick;
      if (bus_if.ram_refresh === 1'b1) begin
        rf_cnt++; rf_last = t;
        if (rf_first < 0) rf_first = t;
        if (prev_rf === 1'b0) rf_rises++;
      end
      prev_rf = bus_if.ram_refresh;
      if (bus_if.ram_cs === 1'b1 && cs_first < 0) cs_first = t;
      if (bus_if.a_ack === 1'b1) begin ack_t = t; bus_if.a_req = 1'b0; end
      if (t == exp_rf + 2) bus_if.a_req = 1'b1;
    end
    n_checks++;
    if (rf_first !== exp_rf || rf_last !== exp_rf + RHIGH - 1 || rf_cnt !== RHIGH || rf_rises !== 1) begin
      n_fail++;
      $display("FAIL refresh_strobe: got first=%0d last=%0d cnt=%0d rises=%0d, want %0d %0d %0d 1",
               rf_first, rf_last, rf_cnt, rf_rises, exp_rf, exp_rf + RHIGH - 1, RHIGH);
    end
    n_checks++;
    if (cs_first !== exp_rf + RLEN + 1 || ack_t !== exp_rf + RLEN + 1 + CYC) begin
      n_fail++;
      $display("FAIL refresh_then_grant: got cs_first=%0d ack=%0d, want %0d %0d",
               cs_first, ack_t, exp_rf + RLEN + 1, exp_rf + RLEN + 1 + CYC);
    end
    n_checks++;
    if (bus_if.a_dout !== 8'h7E) begin
      n_fail++;
      $display("FAIL refresh_rd_dout: got %h want 7e", bus_if.a_dout);
    end
  endtask

  // Scenario: async reset on the third cs-high clock aborts the access silently.
  task automatic test_reset_mid;
    int acks = 0, cs_hi = 0;
    do_reset(1'b1);
    bus_if.a_we = 1'b1; bus_if.a_addr = 25'h0ABCDEF; bus_if.a_din = 8'hE7; bus_if.a_req = 1'b1;
    tick;
    tick;
    tick;
    reset_n = 1'b0;
    bus_if.a_req = 1'b0;
    #1;
    n_checks++;
    if ({bus_if.ram_cs, bus_if.ram_we, bus_if.ram_addr, bus_if.a_ack, bus_if.b_ack} !== 28'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got cs=%b we=%b addr=%h aack=%b back=%b, want all 0",
               bus_if.ram_cs, bus_if.ram_we, bus_if.ram_addr, bus_if.a_ack, bus_if.b_ack);
    end
    tick;
    reset_n = 1'b1;
    for (int t = 0; t < 2 * CYC; t++) begin
      tick;
      if (bus_if.a_ack === 1'b1 || bus_if.b_ack === 1'b1) acks++;
      if (bus_if.ram_cs === 1'b1) cs_hi++;
    end
    n_checks++;
    if (acks !== 0 || cs_hi !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_no_ack: got acks=%0d cs_clocks=%0d, want 0 0", acks, cs_hi);
    end
  endtask

  // Scenario: ram_ready low blocks grants and refresh; raising it grants at once.
  task automatic test_ready_low;
    int cs_hi = 0, rf_hi = 0;
    do_reset(1'b0);
    bus_if.a_we = 1'b1; bus_if.a_addr = 25'h0000042; bus_if.a_din = 8'h24; bus_if.a_req = 1'b1;
    for (int t = 0; t < RCYC + 20; t++) begin
      tick;
      if (bus_if.ram_cs === 1'b1) cs_hi++;
      if (bus_if.ram_refresh === 1'b1) rf_hi++;
    end
    n_checks++;
    if (cs_hi !== 0 || rf_hi !== 0) begin
      n_fail++;
      $display("FAIL notready_idle: got cs_clocks=%0d refresh_clocks=%0d, want 0 0", cs_hi, rf_hi);
    end
    bus_if.ram_ready = 1'b1;
    tick;
    n_checks++;
    if ({bus_if.ram_cs, bus_if.ram_addr} !== {1'b1, 25'h0000042}) begin
      n_fail++;
      $display("FAIL ready_grant: got cs=%b addr=%h, want 1 0000042", bus_if.ram_cs, bus_if.ram_addr);
    end
    for (int i = 0; i < CYC; i++) tick;
    n_checks++;
    if (bus_if.a_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_ack: got %b want 1", bus_if.a_ack);
    end
    bus_if.a_req = 1'b0;
    tick;
  endtask

  // Randomized run: transaction model predicts grant order, slot contents and douts.
  task automatic test_random;
    logic        r_we[2];
    logic [24:0] r_addr[2];
    logic [7:0]  r_din[2];
    logic [7:0]  r_dout[2];
    logic [7:0]  exp_dout[2];
    int order[2];
    int n_items, mode, p;
    bit got, bad;
    do_reset(1'b1);
    exp_dout[0] = 8'h00; exp_dout[1] = 8'h00;
    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(0, 2);
      for (int k = 0; k < 2; k++) begin
        r_we[k]   = 1'($urandom_range(0, 1));
        r_addr[k] = 25'($urandom);
        r_din[k]  = 8'($urandom);
        r_dout[k] = 8'($urandom);
      end
      bus_if.a_we = r_we[0]; bus_if.a_addr = r_addr[0]; bus_if.a_din = r_din[0];
      bus_if.b_we = r_we[1]; bus_if.b_addr = r_addr[1]; bus_if.b_din = r_din[1];
      if (mode == 0) begin n_items = 1; order[0] = 0; bus_if.a_req = 1'b1; end
      else if (mode == 1) begin n_items = 1; order[0] = 1; bus_if.b_req = 1'b1; end
      else begin n_items = 2; order[0] = 0; order[1] = 1; bus_if.a_req = 1'b1; bus_if.b_req = 1'b1; end
      for (int k = 0; k < n_items; k++) begin
        p = order[k];
        bus_if.ram_dout = r_dout[p];
        got = 1'b0;
        for (int w = 0; w < 40 && !got; w++) begin
          tick;
          if (bus_if.ram_cs === 1'b1) got = 1'b1;
        end
        n_checks++;
        if (!got || {bus_if.ram_we, bus_if.ram_addr, bus_if.ram_din} !== {r_we[p], r_addr[p], r_din[p]}) begin
          n_fail++;
          $display("FAIL rnd_grant it%0d port%0d: got cs=%b we=%b addr=%h din=%h, want 1 %b %h %h",
                   it, p, bus_if.ram_cs, bus_if.ram_we, bus_if.ram_addr, bus_if.ram_din,
                   r_we[p], r_addr[p], r_din[p]);
        end
        if (got) begin
          bad = 1'b0;
          for (int j = 1; j < CYC; j++) begin
            tick;
            if ({bus_if.ram_cs, bus_if.ram_we, bus_if.ram_addr, bus_if.ram_din} !==
                {1'b1, r_we[p], r_addr[p], r_din[p]}) bad = 1'b1;
          end
          tick;
          if (!r_we[p]) exp_dout[p] = r_dout[p];
          n_checks++;
          if (bad || bus_if.ram_cs !== 1'b0 || bus_if.a_ack !== (p == 0) || bus_if.b_ack !== (p == 1) ||
              bus_if.a_dout !== exp_dout[0] || bus_if.b_dout !== exp_dout[1]) begin
            n_fail++;
            $display("FAIL rnd_done it%0d port%0d: unstable=%b cs=%b aack=%b back=%b adout=%h bdout=%h, want 0 0 %b %b %h %h",
                     it, p, bad, bus_if.ram_cs, bus_if.a_ack, bus_if.b_ack, bus_if.a_dout, bus_if.b_dout,
                     (p == 0), (p == 1), exp_dout[0], exp_dout[1]);
          end
        end
        if (p == 0) bus_if.a_req = 1'b0; else bus_if.b_req = 1'b0;
      end
      bus_if.a_req = 1'b0; bus_if.b_req = 1'b0;
      for (int w = $urandom_range(1, 4); w > 0; w--) tick;
    end
  endtask

  initial begin
    test_reset;
    test_write_a;
    test_read_b;
    test_contention;
    test_refresh;
    test_reset_mid;
    test_ready_low;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end
endmodule
